clock_step_controller: RTL and testbench

- Sequences the MIPS core clock-enable from the 50 MHz board clock.
- Supports three operating modes:
  - free-run at a programmable divide ratio;
  - single-step from a debounced push-button;
  - halt.
- Sits between the board clock pin and the processor.
- The processor's registers advance only on cycles where Cpu_En=1.
- Also counts executed processor cycles for the debug display.

---
 rtl/clock_step_controller.sv | 199 +++++++++++++++++++
 tb/tb_clock_step_controller.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_step_controller.sv
// Core clock-enable sequencer: free-run divider, debounced single-step, halt.
// Optional breakpoint stop when CLKCTL_BREAKPOINT_EN is defined.
//
// Ports:
//   Input_Clk   board clock (only clock)
//   Reset       async active-high reset
//   Run_Req     level, request free-run
//   Halt_Req    pulse, force halt
//   Step_Btn    raw push-button
//   Div_Value   new divisor, Div_Load pulse applies it
//   Div_Ack     pulse, divisor applied
//   Cpu_En      one-cycle core enable
//   Cpu_Tick    toggles per Cpu_En
//   State       00 HALT, 01 RUN, 10 STEP, 11 BREAK
//   Cycle_Count Cpu_En pulses since reset
//   Bp_Addr/Pc/Bp_Valid  breakpoint inputs (macro only)

module clock_step_controller #(
  parameter int DIV_WIDTH   = 8,
  parameter int DEFAULT_DIV = 25,
  parameter int CYC_WIDTH   = 16,
  parameter int DEB_CYCLES  = 4
) (
  input  logic                 Input_Clk,
  input  logic                 Reset,
  input  logic                 Run_Req,
  input  logic                 Halt_Req,
  input  logic                 Step_Btn,
  input  logic [DIV_WIDTH-1:0] Div_Value,
  input  logic                 Div_Load,
  output logic                 Div_Ack,
  output logic                 Cpu_En,
  output logic                 Cpu_Tick,
  output logic [1:0]           State,
  output logic [CYC_WIDTH-1:0] Cycle_Count
`ifdef CLKCTL_BREAKPOINT_EN
  ,
  input  logic [31:0]          Bp_Addr,
  input  logic [31:0]          Pc,
  input  logic                 Bp_Valid
`endif
);

  localparam int DCW = $clog2(DEB_CYCLES + 1);

  typedef enum logic [1:0] {
    S_HALT  = 2'b00,
    S_RUN   = 2'b01,
    S_STEP  = 2'b10,
    S_BREAK = 2'b11
  } state_e;

  state_e               state_q;
  logic [DIV_WIDTH-1:0] cnt_q;
  logic [DIV_WIDTH-1:0] div_q;
  logic                 en_q;
  logic                 tick_q;
  logic                 ack_q;
  logic [CYC_WIDTH-1:0] cyc_q;

  logic                 sync1_q;
  logic                 sync2_q;
  logic                 deb_q;
  logic [DCW-1:0]       deb_cnt_q;
  logic                 step_q;

  logic [DIV_WIDTH-1:0] eff_div_d;
  logic                 term_d;

  // A zero divisor behaves as one: enable every clock.
  assign eff_div_d = (div_q == '0) ? DIV_WIDTH'(1) : div_q;
  assign term_d    = (cnt_q == eff_div_d - DIV_WIDTH'(1));

`ifdef CLKCTL_BREAKPOINT_EN
  logic en_d1_q;
  logic run_d1_q;
  logic bp_hit_d;
  logic run_fall_d;

  // Pc reflects the instruction reached by the previous enable.
  assign bp_hit_d   = en_d1_q & Bp_Valid & (Pc == Bp_Addr);
  assign run_fall_d = run_d1_q & ~Run_Req;

  always_ff @(posedge Input_Clk or posedge Reset) begin
    if (Reset) begin
      en_d1_q  <= 1'b0;
      run_d1_q <= 1'b0;
    end else begin
      en_d1_q  <= en_q;
      run_d1_q <= Run_Req;
    end
  end
`endif

  // Button: 2-flop sync, then accept a new level after
  // DEB_CYCLES consecutive samples that differ from it.
  always_ff @(posedge Input_Clk or posedge Reset) begin
    if (Reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      deb_q     <= 1'b0;
      deb_cnt_q <= '0;
      step_q    <= 1'b0;
    end else begin
      sync1_q <= Step_Btn;
      sync2_q <= sync1_q;
      step_q  <= 1'b0;
      if (sync2_q == deb_q) begin
        deb_cnt_q <= '0;
      end else if (deb_cnt_q == DCW'(DEB_CYCLES - 1)) begin
        deb_q     <= sync2_q;
        deb_cnt_q <= '0;
        step_q    <= sync2_q;
      end else begin
        deb_cnt_q <= deb_cnt_q + DCW'(1);
      end
    end
  end

  always_ff @(posedge Input_Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_HALT;
      cnt_q   <= '0;
      div_q   <= DIV_WIDTH'(DEFAULT_DIV);
      en_q    <= 1'b0;
      tick_q  <= 1'b0;
      ack_q   <= 1'b0;
      cyc_q   <= '0;
    end else begin
      en_q  <= 1'b0;
      ack_q <= Div_Load;
      if (en_q) begin
        cyc_q  <= cyc_q + CYC_WIDTH'(1);
        tick_q <= ~tick_q;
      end
      if (Halt_Req) begin
        state_q <= S_HALT;
        cnt_q   <= '0;
      end else begin
        unique case (state_q)
          S_HALT: begin
            if (Run_Req) begin
              state_q <= S_RUN;
              cnt_q   <= '0;
            end else if (step_q) begin
              state_q <= S_STEP;
              en_q    <= 1'b1;
            end
          end
          S_RUN: begin
            if (!Run_Req) begin
              state_q <= S_HALT;
              cnt_q   <= '0;
`ifdef CLKCTL_BREAKPOINT_EN
            end else if (bp_hit_d) begin
              state_q <= S_BREAK;
              cnt_q   <= '0;
`endif
            end else if (term_d) begin
              en_q  <= 1'b1;
              cnt_q <= '0;
            end else begin
              cnt_q <= cnt_q + DIV_WIDTH'(1);
            end
          end
          S_STEP: begin
            state_q <= Run_Req ? S_RUN : S_HALT;
            cnt_q   <= '0;
          end
          S_BREAK: begin
`ifdef CLKCTL_BREAKPOINT_EN
            if (step_q) begin
              state_q <= S_STEP;
              en_q    <= 1'b1;
            end else if (run_fall_d) begin
              state_q <= S_HALT;
            end
`else
            state_q <= S_HALT;
`endif
          end
        endcase
      end
      // Reload restarts the period; an enable already
      // decided this cycle still goes out.
      if (Div_Load) begin
        div_q <= Div_Value;
        cnt_q <= '0;
      end
    end
  end

  assign Div_Ack     = ack_q;
  assign Cpu_En      = en_q;
  assign Cpu_Tick    = tick_q;
  assign State       = state_q;
  assign Cycle_Count = cyc_q;

endmodule

// File: tb/tb_clock_step_controller.sv
// Directed bench for clock_step_controller.
// Breakpoint scenario runs only with CLKCTL_BREAKPOINT_EN.

module tb_clock_step_controller;

  logic        Input_Clk = 1'b0;
  logic        Reset     = 1'b1;
  logic        Run_Req   = 1'b0;
  logic        Halt_Req  = 1'b0;
  logic        Step_Btn  = 1'b0;
  logic [7:0]  Div_Value = 8'd0;
  logic        Div_Load  = 1'b0;
  logic        Div_Ack;
  logic        Cpu_En;
  logic        Cpu_Tick;
  logic [1:0]  State;
  logic [15:0] Cycle_Count;

  int checks   = 0;
  int failures = 0;

`ifdef CLKCTL_BREAKPOINT_EN
  logic [31:0] Bp_Addr  = 32'h0000_0010;
  logic        Bp_Valid = 1'b0;
  logic [31:0] Pc;
  int          bp_n = 0;

  always @(posedge Input_Clk) begin
    if (Reset) bp_n <= 0;
    else if (Cpu_En) bp_n <= bp_n + 1;
  end
  assign Pc = (bp_n == 0) ? 32'd0 : 32'((bp_n - 1) * 4);
`endif

  always #5 Input_Clk = ~Input_Clk;

  clock_step_controller dut (
    .Input_Clk   (Input_Clk),
    .Reset       (Reset),
    .Run_Req     (Run_Req),
    .Halt_Req    (Halt_Req),
    .Step_Btn    (Step_Btn),
    .Div_Value   (Div_Value),
    .Div_Load    (Div_Load),
    .Div_Ack     (Div_Ack),
    .Cpu_En      (Cpu_En),
    .Cpu_Tick    (Cpu_Tick),
    .State       (State),
    .Cycle_Count (Cycle_Count)
`ifdef CLKCTL_BREAKPOINT_EN
    ,
    .Bp_Addr     (Bp_Addr),
    .Pc          (Pc),
    .Bp_Valid    (Bp_Valid)
`endif
  );

  task automatic tick;
    @(posedge Input_Clk);
    #1;
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({State, Cpu_En, Cpu_Tick, Div_Ack} !== 5'b0
        || Cycle_Count !== 16'd0) begin
      failures++;
      $display("FAIL reset_state: st=%b en=%b tk=%b ack=%b cyc=%0d want 0",
               State, Cpu_En, Cpu_Tick, Div_Ack, Cycle_Count);
    end
    Reset = 1'b0;
    tick();
  endtask

  task automatic test_default_divide;
    Run_Req = 1'b1;
    tick();
    checks++;
    if (State !== 2'b01) begin
      failures++;
      $display("FAIL run_entry: state=%b want 01", State);
    end
    for (int i = 1; i <= 101; i++) begin
      tick();
      checks++;
      if (Cpu_En !== ((i % 25) == 0)) begin
        failures++;
        $display("FAIL div25_en i=%0d: en=%b want %b",
                 i, Cpu_En, ((i % 25) == 0));
      end
      if (i == 30 || i == 60 || i == 80) begin
        checks++;
        if (Cpu_Tick !== (i != 60)) begin
          failures++;
          $display("FAIL cpu_tick i=%0d: tick=%b want %b",
                   i, Cpu_Tick, (i != 60));
        end
      end
    end
    checks++;
    if (Cycle_Count !== 16'd4) begin
      failures++;
      $display("FAIL cycle_count_100: got %0d want 4", Cycle_Count);
    end
  endtask

  task automatic test_div_reload;
    Div_Value = 8'd3;
    Div_Load  = 1'b1;
    tick();
    Div_Load  = 1'b0;
    checks++;
    if (Div_Ack !== 1'b1 || Cpu_En !== 1'b0) begin
      failures++;
      $display("FAIL div3_ack: ack=%b en=%b want 1 0", Div_Ack, Cpu_En);
    end
    for (int j = 1; j <= 9; j++) begin
      tick();
      checks++;
      if (Cpu_En !== ((j % 3) == 0) || (j == 1 && Div_Ack !== 1'b0)) begin
        failures++;
        $display("FAIL div3_en j=%0d: en=%b ack=%b want en %b",
                 j, Cpu_En, Div_Ack, ((j % 3) == 0));
      end
    end
    Div_Value = 8'd0;
    Div_Load  = 1'b1;
    tick();
    Div_Load  = 1'b0;
    checks++;
    if (Div_Ack !== 1'b1 || Cpu_En !== 1'b0) begin
      failures++;
      $display("FAIL div0_ack: ack=%b en=%b want 1 0", Div_Ack, Cpu_En);
    end
    for (int j = 1; j <= 8; j++) begin
      tick();
      checks++;
      if (Cpu_En !== 1'b1) begin
        failures++;
        $display("FAIL div0_en j=%0d: en=%b want 1", j, Cpu_En);
      end
    end
    Run_Req = 1'b0;
    tick();
    checks++;
    if (State !== 2'b00 || Cpu_En !== 1'b0) begin
      failures++;
      $display("FAIL run_drop: state=%b en=%b want 00 0", State, Cpu_En);
    end
  endtask

  task automatic test_single_step;
    int en_n;
    int step_n;
    int en_in_step;
    en_n = 0;
    step_n = 0;
    en_in_step = 0;
    for (int t = 0; t < 30; t++) begin
      Step_Btn = (t < 2) || (t >= 4 && t < 16);
      tick();
      if (Cpu_En) en_n++;
      if (State == 2'b10) step_n++;
      if (Cpu_En && State == 2'b10) en_in_step++;
    end
    Step_Btn = 1'b0;
    checks++;
    if (en_n != 1 || step_n != 1 || en_in_step != 1 || State !== 2'b00) begin
      failures++;
      $display("FAIL single_step: en=%0d step=%0d both=%0d st=%b want 1 1 1 00",
               en_n, step_n, en_in_step, State);
    end
  endtask

  task automatic test_step_in_run;
    Div_Value = 8'd25;
    Div_Load  = 1'b1;
    tick();
    Div_Load  = 1'b0;
    checks++;
    if (Div_Ack !== 1'b1) begin
      failures++;
      $display("FAIL div25_ack: ack=%b want 1", Div_Ack);
    end
    Run_Req = 1'b1;
    tick();
    for (int i = 1; i <= 60; i++) begin
      Step_Btn = (i <= 12);
      tick();
      checks++;
      if (Cpu_En !== ((i % 25) == 0) || State !== 2'b01) begin
        failures++;
        $display("FAIL step_in_run i=%0d: en=%b st=%b want %b 01",
                 i, Cpu_En, State, ((i % 25) == 0));
      end
    end
    Step_Btn = 1'b0;
  endtask

  task automatic test_halt_priority;
    int en_n;
    en_n = 0;
    Halt_Req = 1'b1;
    tick();
    Halt_Req = 1'b0;
    Run_Req  = 1'b0;
    checks++;
    if (State !== 2'b00 || Cpu_En !== 1'b0) begin
      failures++;
      $display("FAIL halt_prio: st=%b en=%b want 00 0", State, Cpu_En);
    end
    for (int i = 0; i < 40; i++) begin
      tick();
      if (Cpu_En) en_n++;
    end
    checks++;
    if (en_n != 0 || State !== 2'b00) begin
      failures++;
      $display("FAIL halt_quiet: en=%0d st=%b want 0 00", en_n, State);
    end
    Run_Req = 1'b1;
    tick();
    for (int i = 1; i <= 25; i++) begin
      tick();
      checks++;
      if (Cpu_En !== (i == 25)) begin
        failures++;
        $display("FAIL halt_cnt_clr i=%0d: en=%b want %b",
                 i, Cpu_En, (i == 25));
      end
    end
  endtask

  task automatic test_async_reset;
    repeat (12) tick();
    #3;
    Reset = 1'b1;
    #1;
    checks++;
    if ({State, Cpu_En, Cpu_Tick, Div_Ack} !== 5'b0
        || Cycle_Count !== 16'd0) begin
      failures++;
      $display("FAIL async_reset: st=%b en=%b tk=%b ack=%b cyc=%0d want 0",
               State, Cpu_En, Cpu_Tick, Div_Ack, Cycle_Count);
    end
    tick();
    Reset = 1'b0;
    tick();
    checks++;
    if (State !== 2'b01) begin
      failures++;
      $display("FAIL reset_rerun: st=%b want 01", State);
    end
    for (int i = 1; i <= 25; i++) begin
      tick();
      checks++;
      if (Cpu_En !== (i == 25)) begin
        failures++;
        $display("FAIL reset_first_en i=%0d: en=%b want %b",
                 i, Cpu_En, (i == 25));
      end
    end
  endtask

  task automatic test_wrap;
    tick();
    checks++;
    if (Cycle_Count !== 16'd1) begin
      failures++;
      $display("FAIL count_after_reset: got %0d want 1", Cycle_Count);
    end
    Div_Value = 8'd0;
    Div_Load  = 1'b1;
    tick();
    Div_Load  = 1'b0;
    for (int j = 1; j <= 65535; j++) tick();
    checks++;
    if (Cycle_Count !== 16'hFFFF) begin
      failures++;
      $display("FAIL count_max: got %h want ffff", Cycle_Count);
    end
    tick();
    checks++;
    if (Cycle_Count !== 16'h0000) begin
      failures++;
      $display("FAIL count_wrap: got %h want 0000", Cycle_Count);
    end
    Run_Req = 1'b0;
    tick();
  endtask

`ifdef CLKCTL_BREAKPOINT_EN
  task automatic test_breakpoint;
    bit hit;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    Div_Value = 8'd3;
    Div_Load  = 1'b1;
    tick();
    Div_Load  = 1'b0;
    Bp_Valid  = 1'b1;
    Run_Req   = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      tick();
      if (State == 2'b11) hit = 1'b1;
    end
    checks++;
    if (!hit || bp_n != 5) begin
      failures++;
      $display("FAIL bp_hit: hit=%b n=%0d want 1 5", hit, bp_n);
    end
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (State !== 2'b11 || Cpu_En !== 1'b0 || bp_n != 5) begin
      failures++;
      $display("FAIL bp_hold: st=%b en=%b n=%0d want 11 0 5",
               State, Cpu_En, bp_n);
    end
    Step_Btn = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin
      tick();
      if (State == 2'b10) hit = 1'b1;
    end
    checks++;
    if (!hit || Cpu_En !== 1'b1) begin
      failures++;
      $display("FAIL bp_step: hit=%b en=%b want 1 1", hit, Cpu_En);
    end
    Run_Req  = 1'b0;
    Step_Btn = 1'b0;
    tick();
    checks++;
    if (State !== 2'b00 || Cpu_En !== 1'b0 || bp_n != 6) begin
      failures++;
      $display("FAIL bp_after_step: st=%b en=%b n=%0d want 00 0 6",
               State, Cpu_En, bp_n);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_default_divide();
    test_div_reload();
    test_single_step();
    test_step_in_run();
    test_halt_priority();
    test_async_reset();
    test_wrap();
`ifdef CLKCTL_BREAKPOINT_EN
    test_breakpoint();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
